atc_uart_tx: RTL and testbench



---
 rtl/atc_pkg.sv | 24 ++
 rtl/atc_baud_gen.sv | 30 +++
 rtl/atc_uart_tx.sv | 158 +++++++++++++++
 tb/tb_atc_uart_tx.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/atc_pkg.sv
// Shared definitions for the ATC serial command receiver and reply transmitter.
package atc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 217;

    // Wide enough for the largest legal bit period (4095 clocks).
    localparam int BAUD_CNT_W = 12;

    localparam int FRAME_BITS_PARITY    = 11;
    localparam int FRAME_BITS_NO_PARITY = 10;

    function automatic int frame_clocks(input int clks_per_bit, input bit parity_en);
        return clks_per_bit * (parity_en ? FRAME_BITS_PARITY : FRAME_BITS_NO_PARITY);
    endfunction

endpackage

// File: rtl/atc_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, pulses bit_done on the last count,
// and is held/cleared by restart so each FSM state starts on a fresh bit period.
module atc_baud_gen
    import atc_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic bit_done
);

    localparam logic [BAUD_CNT_W-1:0] LAST_CNT = BAUD_CNT_W'(CLKS_PER_BIT - 1);

    logic [BAUD_CNT_W-1:0] baud_cnt_reg;

    always_ff @(posedge clock) begin
        if (reset || restart) begin
            baud_cnt_reg <= '0;
        end else if (baud_cnt_reg == LAST_CNT) begin
            baud_cnt_reg <= '0;
        end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
        end
    end

    assign bit_done = (baud_cnt_reg == LAST_CNT);

endmodule

// File: rtl/atc_uart_tx.sv
// 8N1 serial transmitter with a one-entry holding buffer and gapless back-to-back frames.
// Defining ATC_UART_PARITY_EN adds an even parity bit (8E1 frames).
module atc_uart_tx
    import atc_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       send,
    output logic       ready,
    output logic       tx,
    output logic       sending
);

    tx_state_t  state_reg, state_next;
    logic [7:0] buf_data_reg, buf_data_next;
    logic       buf_valid_reg, buf_valid_next;
    logic [7:0] shreg_reg, shreg_next;
    logic [2:0] bit_idx_reg, bit_idx_next;
    logic       tx_reg, tx_next;
`ifdef ATC_UART_PARITY_EN
    logic       parity_reg, parity_next;
`endif
    logic       bit_done;
    logic       restart;
    logic       load;
    logic       accept;

    atc_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clock   (clock),
        .reset   (reset),
        .restart (restart),
        .bit_done(bit_done)
    );

    always_comb begin
        state_next     = state_reg;
        shreg_next     = shreg_reg;
        bit_idx_next   = bit_idx_reg;
        buf_data_next  = buf_data_reg;
        buf_valid_next = buf_valid_reg;
        load           = 1'b0;
        accept         = send && !buf_valid_reg;
`ifdef ATC_UART_PARITY_EN
        parity_next    = parity_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (buf_valid_reg) begin
                    load = 1'b1;
                end
            end
            START: begin
                if (bit_done) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx_reg == 3'd7) begin
                        bit_idx_next = 3'd0;
`ifdef ATC_UART_PARITY_EN
                        state_next   = PARITY;
`else
                        state_next   = STOP;
`endif
                    end else begin
                        shreg_next   = {1'b0, shreg_reg[7:1]};
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end
`ifdef ATC_UART_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                // A byte already waiting starts immediately, with no idle cycle.
                if (bit_done) begin
                    if (buf_valid_reg) begin
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (load) begin
            state_next     = START;
            shreg_next     = buf_data_reg;
            bit_idx_next   = 3'd0;
            buf_valid_next = 1'b0;
`ifdef ATC_UART_PARITY_EN
            parity_next    = ^buf_data_reg;
`endif
        end

        if (accept) begin
            buf_valid_next = 1'b1;
            buf_data_next  = data;
        end

        // Every state entry starts a fresh bit period; IDLE keeps the timer parked.
        restart = (state_next != state_reg) || (state_reg == IDLE);

        case (state_next)
            IDLE:    tx_next = 1'b1;
            START:   tx_next = 1'b0;
            DATA:    tx_next = shreg_next[0];
`ifdef ATC_UART_PARITY_EN
            PARITY:  tx_next = parity_next;
`endif
            STOP:    tx_next = 1'b1;
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            buf_data_reg  <= '0;
            buf_valid_reg <= 1'b0;
            shreg_reg     <= '0;
            bit_idx_reg   <= '0;
            tx_reg        <= 1'b1;
`ifdef ATC_UART_PARITY_EN
            parity_reg    <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            buf_data_reg  <= buf_data_next;
            buf_valid_reg <= buf_valid_next;
            shreg_reg     <= shreg_next;
            bit_idx_reg   <= bit_idx_next;
            tx_reg        <= tx_next;
`ifdef ATC_UART_PARITY_EN
            parity_reg    <= parity_next;
`endif
        end
    end

    assign tx      = tx_reg;
    assign ready   = !buf_valid_reg;
    assign sending = (state_reg != IDLE);

endmodule

// File: tb/tb_atc_uart_tx.sv
// Self-checking bench for atc_uart_tx: cycle-by-cycle comparison against a queue-based
// line model, directed scenarios followed by randomized traffic.
module tb_atc_uart_tx;

    localparam int CPB = 4;
`ifdef ATC_UART_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int FRAME_LEN = CPB * (PAR_EN ? 11 : 10);

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       send  = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       ready;
    logic       tx;
    logic       sending;

    atc_uart_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .data   (data),
        .send   (send),
        .ready  (ready),
        .tx     (tx),
        .sending(sending)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Expected line level for the current and all remaining cycles of the frame in flight.
    bit         line_q[$];
    bit         m_buf_v = 1'b0;
    logic [7:0] m_buf_d = 8'h00;
    int         run_len = 0;
    int         last_run = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] b);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
        if (PAR_EN) bits.push_back(($countones(b) % 2) == 1);
        bits.push_back(1'b1);
        foreach (bits[i]) begin
            for (int c = 0; c < CPB; c++) line_q.push_back(bits[i]);
        end
        $display("frame  start data=0x%02h at t=%0t", b, $time);
    endtask

    task automatic step(input bit s, input logic [7:0] d, input bit r);
        bit   old_v;
        logic exp_tx;
        logic exp_sending;
        send  = s;
        data  = d;
        reset = r;
        @(posedge clock);
        if (r) begin
            line_q.delete();
            m_buf_v = 1'b0;
        end else begin
            old_v = m_buf_v;
            if (line_q.size() > 0) void'(line_q.pop_front());
            if (line_q.size() == 0 && old_v) begin
                push_frame(m_buf_d);
                m_buf_v = 1'b0;
            end
            if (s && !old_v) begin
                m_buf_v = 1'b1;
                m_buf_d = d;
                $display("accept data=0x%02h at t=%0t", d, $time);
            end
        end
        #1;
        exp_tx      = (line_q.size() > 0) ? line_q[0] : 1'b1;
        exp_sending = (line_q.size() > 0);
        check_value("tx", 32'(tx), 32'(exp_tx));
        check_value("sending", 32'(sending), 32'(exp_sending));
        check_value("ready", 32'(ready), 32'(!m_buf_v));
        if (sending === 1'b1) begin
            run_len++;
        end else if (run_len > 0) begin
            last_run = run_len;
            run_len  = 0;
        end
        send = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * FRAME_LEN && (line_q.size() > 0 || m_buf_v); i++) begin
            step(1'b0, 8'h00, 1'b0);
        end
        step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        check_value("rst_tx", 32'(tx), 32'd1);
        check_value("rst_ready", 32'(ready), 32'd1);
        check_value("rst_sending", 32'(sending), 32'd0);
        step(1'b0, 8'h00, 1'b0);

        // Single byte 0x0E
        last_run = 0;
        step(1'b1, 8'h0E, 1'b0);
        drain();
        check_value("single_run", 32'(last_run), 32'(FRAME_LEN));

        // Back-to-back 0x55 then 0xAA, plus 0xFF offered while the buffer is full
        last_run = 0;
        step(1'b1, 8'h55, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'hAA, 1'b0);
        repeat (8) step(1'b1, 8'hFF, 1'b0);
        drain();
        check_value("b2b_run", 32'(last_run), 32'(2 * FRAME_LEN));

        // Parity / frame shape with 0x01
        step(1'b1, 8'h01, 1'b0);
        drain();

        // Reset during data bit 3 with a second byte queued
        step(1'b1, 8'h3C, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h99, 1'b0);
        repeat (4 * CPB - 1) step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check_value("midrst_tx", 32'(tx), 32'd1);
        check_value("midrst_sending", 32'(sending), 32'd0);
        check_value("midrst_ready", 32'(ready), 32'd1);
        repeat (2 * FRAME_LEN) step(1'b0, 8'h00, 1'b0);

        // Accept on the last stop cycle with an empty buffer: one idle cycle
        step(1'b1, 8'hA5, 1'b0);
        repeat (FRAME_LEN) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h5A, 1'b0);
        check_value("gap_sending", 32'(sending), 32'd0);
        check_value("gap_tx", 32'(tx), 32'd1);
        step(1'b0, 8'h00, 1'b0);
        check_value("gap_start", 32'(tx), 32'd0);
        drain();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 299) == 0));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
